shift_arbiter_seq: RTL
======================

Name: shift_arbiter_seq

Overview:
- Sequencing and arbitration controller that shares one combinational 8-bit shifter unit between two requesters.
- Each request carries data, an operation code and a shift amount of 0..15.
- Amounts above the shifter's 3-bit per-pass limit are executed as multiple passes.
- Results are registered and returned on a valid/ready response channel tagged with the requester ID.

Parameters:
- DATA_W, 8, datapath width; fixed to the shifter width.
- AMT_W, 4, request shift-amount width; maximum amount 15.
- STEP_MAX, 7, maximum shift per pass; equals the shifter count limit.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- req_valid  input  2  per-requester request valid.
- req_ready  output  2  per-requester accept; at most one bit high.
- req_data0  input  8  requester 0 operand.
- req_op0  input  3  requester 0 op code (shift_op_e).
- req_amt0  input  4  requester 0 shift amount.
- req_data1  input  8  requester 1 operand.
- req_op1  input  3  requester 1 op code.
- req_amt1  input  4  requester 1 shift amount.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts result.
- rsp_data  output  8  shifted result.
- rsp_id  output  1  requester that owns rsp_data.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Op codes (shifter select encoding): 0 PASS, 1 SLL, 2 SLA, 3 SRL, 4 SRA, 5 ROL, 6 ROR, 7 PASS.
- FSM states: IDLE, BUSY, DONE. Reset values: state IDLE, rsp_valid 0, rsp_data 0, rsp_id 0, last_grant 1, internal accumulator and remaining count 0.
- req_ready (combinational):
  - All bits 0 unless state is IDLE and rst is low.
  - In IDLE, round-robin grant: if both requesters are valid, the one not equal to last_grant wins; if only one is valid, it wins; otherwise no bit is high.
- Accept: a handshake (req_valid[i] & req_ready[i]) at a rising edge latches acc = data, op, rem = amt, id = i, and updates last_grant = i.
  - If amt == 0 or op is PASS: next state is DONE, rsp_data = data, zero BUSY cycles.
  - Otherwise: next state is BUSY.
- BUSY, one pass per cycle:
  - step = min(rem, STEP_MAX).
  - acc <= shifter(acc, op, step).
  - rem <= rem - step.
  - When rem - step == 0: rsp_data <= new acc and next state is DONE.
  - Number of BUSY cycles is ceil(amt/7): 1 for amounts 1..7, 2 for 8..14, 3 for 15.
- Multi-pass equivalence:
  - Logical and arithmetic shifts compose additively; logical shifts of 8 or more give 0.
  - SRA of 8 or more gives all sign bits.
  - Rotates compose modulo 8.
- DONE: rsp_valid is high. rsp_data and rsp_id are held stable until rsp_ready. On the rsp_valid & rsp_ready edge, rsp_valid drops and the state returns to IDLE.
  - No new request is accepted in the same cycle, so there is one IDLE cycle minimum between jobs.
- Request inputs are ignored outside the accept edge; requesters may change them after the handshake.
- Reset mid-operation (BUSY or DONE): the job is aborted with no response, and all reset values are restored on the next edge.
- Back-to-back requests with both requesters valid: grants strictly alternate 0,1,0,1,...

Decomposition:
- Package shift_pkg:
  - typedef enum logic [2:0] shift_op_e (codes as above).
  - Constants DATA_W = 8, STEP_MAX = 7.
  - FSM state typedef.
- Sub-module shift_unit: the combinational shifter (d_in, sel, shift_count, d_out). Instantiated once, driven by acc/op/step.

Test Plan:
1. Req0 0x9D, SLL, amt 2 -> one BUSY cycle, rsp_data 0x74, rsp_id 0; 0x9D with SLA amt 2 also gives 0x74.
2. Req1 0x9D, ROR, amt 10 -> two BUSY cycles (passes of 7 then 3), rsp_data 0x67, rsp_id 1.
3. Req0 0x9D, SRA, amt 15 -> three BUSY cycles, rsp_data 0xFF. Then 0x9D SRL amt 9 -> 0x00. Then 0x9D ROL amt 2 -> 0x76.
4. Both req_valid held high from reset with 4 queued jobs each -> grants 0,1,0,1; req_ready never has 2 bits set; rsp_id sequence matches.
5. rsp_ready held low 3 cycles in DONE -> rsp_valid, rsp_data and rsp_id stable, req_ready = 00, busy = 1. Release rsp_ready -> IDLE next cycle.
6. Assert rst during a BUSY pass of a 0x9D SRL 15 job -> rsp_valid 0, no response emitted. Next request 0x9D SLL amt 0 -> zero BUSY cycles, rsp_data 0x9D, rsp_id correct.

Source files
------------

// File: rtl/shift_pkg.sv
// +----------------------------------------------------------------------------+
// | shift_pkg : shared types and constants for the shift arbiter sequencer      |
// | Rev 1.0   : initial release                                                 |
// +----------------------------------------------------------------------------+
`default_nettype none

package shift_pkg;

  localparam int DATA_W   = 8;
  localparam int AMT_W    = 4;
  localparam int STEP_MAX = 7;
  localparam int CNT_W    = 3;

  typedef enum logic [2:0] {
    OP_PASS  = 3'd0,
    OP_SLL   = 3'd1,
    OP_SLA   = 3'd2,
    OP_SRL   = 3'd3,
    OP_SRA   = 3'd4,
    OP_ROL   = 3'd5,
    OP_ROR   = 3'd6,
    OP_PASS7 = 3'd7
  } shift_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic is_pass(input shift_op_e op);
    return (op == OP_PASS) || (op == OP_PASS7);
  endfunction

  // One pass moves at most STEP_MAX positions; larger amounts take extra passes.
  function automatic logic [CNT_W-1:0] step_of(input logic [AMT_W-1:0] rem);
    if (rem > AMT_W'(STEP_MAX))
      return CNT_W'(STEP_MAX);
    else
      return rem[CNT_W-1:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/shift_arbiter_seq_shift_unit.sv
// +----------------------------------------------------------------------------+
// | shift_unit : combinational 8-bit shifter, count limited to 0..7             |
// | Rev 1.0    : initial release                                                |
// +----------------------------------------------------------------------------+
`default_nettype none

module shift_unit
  import shift_pkg::*;
(
  input  logic [DATA_W-1:0] d_in,
  input  shift_op_e         sel,
  input  logic [CNT_W-1:0]  shift_count,
  output logic [DATA_W-1:0] d_out
);

  logic [2*DATA_W-1:0] w_dbl;
  logic [2*DATA_W-1:0] w_dbl_l;
  logic [2*DATA_W-1:0] w_dbl_r;

  // Rotates are taken from a doubled copy so the wrapped bits fall in naturally.
  assign w_dbl   = {d_in, d_in};
  assign w_dbl_l = w_dbl << shift_count;
  assign w_dbl_r = w_dbl >> shift_count;

  always_comb begin
    d_out = d_in;
    case (sel)
      OP_SLL, OP_SLA: d_out = d_in << shift_count;
      OP_SRL:         d_out = d_in >> shift_count;
      OP_SRA:         d_out = $signed(d_in) >>> shift_count;
      OP_ROL:         d_out = w_dbl_l[2*DATA_W-1:DATA_W];
      OP_ROR:         d_out = w_dbl_r[DATA_W-1:0];
      default:        d_out = d_in;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/shift_arbiter_seq.sv
// +----------------------------------------------------------------------------+
// | shift_arbiter_seq : round-robin arbiter sequencing multi-pass shift jobs    |
// | Rev 1.0           : initial release                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

module shift_arbiter_seq
  import shift_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [DATA_W-1:0] req_data0,
  input  logic [2:0]        req_op0,
  input  logic [AMT_W-1:0]  req_amt0,
  input  logic [DATA_W-1:0] req_data1,
  input  logic [2:0]        req_op1,
  input  logic [AMT_W-1:0]  req_amt1,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_id,
  output logic              busy
);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [DATA_W-1:0] r_acc;
  shift_op_e         r_op;
  logic [AMT_W-1:0]  r_rem;
  logic              r_last_grant;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_rsp_id;

  logic [1:0]        w_grant;
  logic              w_accept;
  logic              w_sel_id;
  logic [DATA_W-1:0] w_sel_data;
  shift_op_e         w_sel_op;
  logic [AMT_W-1:0]  w_sel_amt;
  logic              w_sel_direct;
  logic [CNT_W-1:0]  w_step;
  logic [AMT_W-1:0]  w_rem_nxt;
  logic [DATA_W-1:0] w_shift_out;

  // Grant only while idle and out of reset; a tie goes to whoever did not win last.
  always_comb begin
    w_grant = 2'b00;
    if (!rst && (r_state == ST_IDLE)) begin
      if (req_valid == 2'b11)
        w_grant = r_last_grant ? 2'b01 : 2'b10;
      else
        w_grant = req_valid;
    end
  end

  assign req_ready = w_grant;
  assign w_accept  = |w_grant;
  assign w_sel_id  = w_grant[1];

  always_comb begin
    w_sel_data = req_data0;
    w_sel_op   = shift_op_e'(req_op0);
    w_sel_amt  = req_amt0;
    if (w_sel_id) begin
      w_sel_data = req_data1;
      w_sel_op   = shift_op_e'(req_op1);
      w_sel_amt  = req_amt1;
    end
  end

  assign w_sel_direct = (w_sel_amt == '0) || is_pass(w_sel_op);
  assign w_step       = step_of(r_rem);
  assign w_rem_nxt    = r_rem - AMT_W'(w_step);

  shift_unit u_shift_unit (
    .d_in        (r_acc),
    .sel         (r_op),
    .shift_count (w_step),
    .d_out       (w_shift_out)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept)
          w_state_nxt = w_sel_direct ? ST_DONE : ST_BUSY;
      end
      ST_BUSY: begin
        if (w_rem_nxt == '0)
          w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (rsp_ready)
          w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_acc        <= '0;
      r_op         <= OP_PASS;
      r_rem        <= '0;
      r_last_grant <= 1'b1;
      r_rsp_valid  <= 1'b0;
      r_rsp_data   <= '0;
      r_rsp_id     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_acc        <= w_sel_data;
            r_op         <= w_sel_op;
            r_rem        <= w_sel_amt;
            r_rsp_id     <= w_sel_id;
            r_last_grant <= w_sel_id;
            if (w_sel_direct) begin
              r_rsp_data  <= w_sel_data;
              r_rsp_valid <= 1'b1;
            end
          end
        end
        ST_BUSY: begin
          r_acc <= w_shift_out;
          r_rem <= w_rem_nxt;
          if (w_rem_nxt == '0) begin
            r_rsp_data  <= w_shift_out;
            r_rsp_valid <= 1'b1;
          end
        end
        ST_DONE: begin
          if (rsp_ready)
            r_rsp_valid <= 1'b0;
        end
        default: r_rsp_valid <= 1'b0;
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_id    = r_rsp_id;
  assign busy      = (r_state != ST_IDLE);

endmodule

`default_nettype wire
